// File: rtl/alu_issue_if.sv
// ALU operand-issue bundle: decoded-stage packet in, EXU operand packet out.
// The issue stage drives the master modport; the upstream/EXU side uses slave.
interface alu_issue_if #(parameter int unsigned XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic [2:0]      alu_opt;
    logic            alu_shamt;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        input  in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, alu_src1, alu_src2, alu_opt, alu_shamt,
               out_rd, out_rd_wen, out_pc, out_illegal
    );

    modport slave (
        output in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, alu_src1, alu_src2, alu_opt, alu_shamt,
               out_rd, out_rd_wen, out_pc, out_illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I operand-issue stage: decodes ALU operands and holds them in a valid/ready register.
// Define ALU_ISSUE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module alu_issue (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [2:0]      opt;
        logic            shamt;
        logic [RW-1:0]   rd;
        logic            rd_wen;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } issue_pkt_t;

    typedef enum logic [1:0] {S_EMPTY, S_MAIN, S_FULL} occ_e;

    occ_e       state_q, state_d;
    issue_pkt_t main_q, main_d;
    issue_pkt_t dec;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       accept;
    logic       drain;

    assign opcode = bus.in_inst[6:0];
    assign f3     = bus.in_inst[14:12];

    // Operand decode, purely combinational on the offered packet
    always_comb begin
        dec         = '0;
        dec.rd      = bus.in_inst[11:7];
        dec.pc      = bus.in_pc;
        case (opcode)
            OPC_OP: begin
                dec.src1  = bus.in_rs1;
                dec.src2  = bus.in_rs2;
                dec.opt   = f3;
                dec.shamt = ((f3 == 3'b000) || (f3 == 3'b101)) && bus.in_inst[30];
            end
            OPC_OPIMM: begin
                dec.src1 = bus.in_rs1;
                dec.opt  = f3;
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    dec.src2  = XLEN'(bus.in_inst[24:20]);
                    dec.shamt = (f3 == 3'b101) && bus.in_inst[30];
                end else begin
                    dec.src2 = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                end
            end
            OPC_LUI: begin
                dec.src2 = {bus.in_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.src1 = bus.in_pc;
                dec.src2 = {bus.in_inst[31:12], 12'b0};
            end
            OPC_JAL, OPC_JALR: begin
                dec.src1 = bus.in_pc;
                dec.src2 = XLEN'(4);
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.rd_wen = !dec.illegal && (dec.rd != '0);
    end

    assign drain  = (state_q != S_EMPTY) && bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready && !flush;

`ifdef ALU_ISSUE_SKID_EN
    issue_pkt_t skid_q, skid_d;
    logic       ready_q;

    assign bus.in_ready = ready_q;
`else
    assign bus.in_ready = (state_q == S_EMPTY) || bus.out_ready;
`endif

    // Occupancy next-state and entry movement; flush overrides everything
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef ALU_ISSUE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = S_MAIN;
                    end
                end
                S_MAIN: begin
                    if (drain) begin
                        if (accept) main_d = dec;
                        else        state_d = S_EMPTY;
                    end
`ifdef ALU_ISSUE_SKID_EN
                    else if (accept) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end
`endif
                end
`ifdef ALU_ISSUE_SKID_EN
                S_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = S_MAIN;
                    end
                end
`endif
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
`ifdef ALU_ISSUE_SKID_EN
            skid_q  <= '0;
            ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef ALU_ISSUE_SKID_EN
            skid_q  <= skid_d;
            ready_q <= (state_d != S_FULL);
`endif
        end
    end

    assign bus.out_valid   = (state_q != S_EMPTY);
    assign bus.alu_src1    = main_q.src1;
    assign bus.alu_src2    = main_q.src2;
    assign bus.alu_opt     = main_q.opt;
    assign bus.alu_shamt   = main_q.shamt;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rd_wen  = main_q.rd_wen;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: spec-level decode model plus a FIFO occupancy model checked every cycle,
// with literal expectations for the directed vectors.
module tb_alu_issue;
`ifdef ALU_ISSUE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [2:0]  opt;
        logic        shamt;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    logic clock;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    bit   model_on = 1'b0;
    exp_t mq[$];

    alu_issue_if bus ();

    alu_issue dut (
        .clock (clock),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // What the EXU must see for an instruction, straight from the RV32I operand rules
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t       e;
        logic [2:0] fn;
        logic [31:0] uimm;
        fn   = inst[14:12];
        uimm = inst & 32'hFFFF_F000;
        e    = '0;
        e.rd = inst[11:7];
        e.pc = pc;
        if (inst[6:0] == 7'h33) begin
            e.src1 = rs1; e.src2 = rs2; e.opt = fn;
            e.shamt = (fn == 3'd0 || fn == 3'd5) ? inst[30] : 1'b0;
        end else if (inst[6:0] == 7'h13) begin
            e.src1 = rs1; e.opt = fn;
            if (fn == 3'd1 || fn == 3'd5) begin
                e.src2  = 32'(inst[24:20]);
                e.shamt = (fn == 3'd5) ? inst[30] : 1'b0;
            end else begin
                e.src2 = 32'($signed(inst) >>> 20);
            end
        end else if (inst[6:0] == 7'h37) begin
            e.src2 = uimm;
        end else if (inst[6:0] == 7'h17) begin
            e.src1 = pc; e.src2 = uimm;
        end else if (inst[6:0] == 7'h6F || inst[6:0] == 7'h67) begin
            e.src1 = pc; e.src2 = 32'd4;
        end else begin
            e.illegal = 1'b1;
        end
        e.rd_wen = !e.illegal && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic bit model_ready();
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || (bus.out_ready == 1'b1);
    endfunction

    // Model update at the active edge using values presented before it
    always @(posedge clock) begin
        if (!rst_n) begin
            mq.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (flush) begin
                mq.delete();
            end else begin
                bit rdy;
                rdy = model_ready();
                if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
                if (bus.in_valid && rdy)
                    mq.push_back(model(bus.in_inst, bus.in_pc, bus.in_rs1, bus.in_rs2));
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (model_on) begin
            check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
            if (bus.out_valid && mq.size() > 0) begin
                check("src1", bus.alu_src1, mq[0].src1);
                check("src2", bus.alu_src2, mq[0].src2);
                check("opt", 32'(bus.alu_opt), 32'(mq[0].opt));
                check("shamt", 32'(bus.alu_shamt), 32'(mq[0].shamt));
                check("rd", 32'(bus.out_rd), 32'(mq[0].rd));
                check("rd_wen", 32'(bus.out_rd_wen), 32'(mq[0].rd_wen));
                check("pc", bus.out_pc, mq[0].pc);
                check("illegal", 32'(bus.out_illegal), 32'(mq[0].illegal));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        present(inst, pc, rs1, rs2);
        tick();
    endtask

    logic [31:0] bp_inst [3];
    logic [31:0] bp_rs1  [3];

    initial begin
        int accepted;
        bit acc;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_src1", bus.alu_src1, 32'd0);
        check("rst_src2", bus.alu_src2, 32'd0);
        check("rst_illegal", 32'(bus.out_illegal), 32'd0);
        check("rst_rd_wen", 32'(bus.out_rd_wen), 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        rst_n = 1'b1;
        tick();

        send(32'h002081B3, 32'h100, 32'd5, 32'd7);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_src1", bus.alu_src1, 32'd5);
        check("add_src2", bus.alu_src2, 32'd7);
        check("add_opt", 32'(bus.alu_opt), 32'd0);
        check("add_shamt", 32'(bus.alu_shamt), 32'd0);
        check("add_rd", 32'(bus.out_rd), 32'd3);
        check("add_rd_wen", 32'(bus.out_rd_wen), 32'd1);

        send(32'h40335293, 32'h104, 32'h80, 32'd0);
        check("srai_src2", bus.alu_src2, 32'd3);
        check("srai_opt", 32'(bus.alu_opt), 32'd5);
        check("srai_shamt", 32'(bus.alu_shamt), 32'd1);

        send(32'h40208033, 32'h108, 32'd1, 32'd2);
        check("sub_shamt", 32'(bus.alu_shamt), 32'd1);
        check("sub_rd_wen", 32'(bus.out_rd_wen), 32'd0);

        send(32'hFFF00093, 32'h10C, 32'd0, 32'd0);
        check("addi_src2", bus.alu_src2, 32'hFFFF_FFFF);
        check("addi_shamt", 32'(bus.alu_shamt), 32'd0);

        send(32'h12345097, 32'h8000_0000, 32'd0, 32'd0);
        check("auipc_src1", bus.alu_src1, 32'h8000_0000);
        check("auipc_src2", bus.alu_src2, 32'h1234_5000);

        send(32'h123452B7, 32'h110, 32'h55, 32'd0);
        check("lui_src1", bus.alu_src1, 32'd0);
        check("lui_src2", bus.alu_src2, 32'h1234_5000);

        send(32'h008000EF, 32'h200, 32'h66, 32'h77);
        check("jal_src1", bus.alu_src1, 32'h200);
        check("jal_src2", bus.alu_src2, 32'd4);

        send(32'h0000_0000, 32'h300, 32'd9, 32'd9);
        check("ill_flag", 32'(bus.out_illegal), 32'd1);
        check("ill_rd_wen", 32'(bus.out_rd_wen), 32'd0);
        check("ill_src1", bus.alu_src1, 32'd0);
        check("ill_src2", bus.alu_src2, 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Back-pressure: offer A, B, C while the EXU stalls for three cycles
        bp_inst[0] = 32'h002081B3; bp_rs1[0] = 32'hA;
        bp_inst[1] = 32'h40208133; bp_rs1[1] = 32'hB;
        bp_inst[2] = 32'h00308193; bp_rs1[2] = 32'hC;
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            present(bp_inst[accepted], 32'h400 + 32'(accepted * 4), bp_rs1[accepted], 32'd1);
            #3;
            acc = bus.in_ready;
            tick();
            if (acc) accepted++;
        end
        check("bp_accepted", 32'(accepted), SKID ? 32'd2 : 32'd1);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold_src1", bus.alu_src1, 32'hA);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && accepted < 3; cyc++) begin
            present(bp_inst[accepted], 32'h400 + 32'(accepted * 4), bp_rs1[accepted], 32'd1);
            #3;
            acc = bus.in_ready;
            tick();
            if (acc) accepted++;
        end
        check("bp_all_accepted", 32'(accepted), 32'd3);
        bus.in_valid = 1'b0;
        repeat (3) tick();

        // Flush while A is held, with a packet offered in the same cycle
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'h500, 32'h11, 32'h22);
        check("fl_held", 32'(bus.out_valid), 32'd1);
        present(32'h00308193, 32'h504, 32'hEE, 32'd0);
        flush = 1'b1;
        tick();
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset during a stall discards everything held
        bus.out_ready = 1'b0;
        send(32'h002081B3, 32'h600, 32'h31, 32'h32);
        send(32'h40208133, 32'h604, 32'h41, 32'h42);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(32'h002081B3, 32'h700, 32'd20, 32'd22);
        check("post_rst_src1", bus.alu_src1, 32'd20);
        check("post_rst_pc", bus.out_pc, 32'h700);
        bus.in_valid = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
